// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for stable DCM lock, stretches reset, then releases
// NUM_CH reset channels in ascending order; restarts on lock loss, button or software request.
module rst_seq_ctrl #(
    parameter int NUM_CH          = 4,
    parameter int STRETCH_CYCLES  = 16,
    parameter int STAGE_GAP       = 8,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST_SYNC,
    input  logic              LOCKED_IN,
    input  logic              BTN_RST_IN,
    input  logic              SW_RST_IN,
    output logic [NUM_CH-1:0] RST_OUT,
    output logic              RST_DONE_OUT,
    output logic [1:0]        RST_CAUSE_OUT,
    output logic [7:0]        LOCK_LOSS_CNT_OUT
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [1:0]  CAUSE_LOCK    = 2'd1;
    localparam logic [1:0]  CAUSE_BTN     = 2'd2;
    localparam logic [1:0]  CAUSE_SW      = 2'd3;
    localparam logic [15:0] STRETCH_LAST  = 16'(STRETCH_CYCLES - 1);
    localparam logic [15:0] GAP_LAST      = 16'(STAGE_GAP - 1);
    localparam logic [19:0] DB_LAST       = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  LAST_CH       = 4'(NUM_CH - 1);

    logic              lock_meta_r, lock_s_r, lock_prev_r;
    logic              btn_meta_r, btn_s_r, btn_db_r;
    logic [19:0]       db_cnt_r;
    logic [7:0]        loss_cnt_r;
    state_t            state_r;
    logic [15:0]       cnt_r;
    logic [3:0]        ch_r;
    logic [NUM_CH-1:0] rst_out_r;
    logic              done_r;
    logic [1:0]        cause_r;
    logic              abort_s;
    logic [1:0]        cause_nxt_s;

    // Two-flop synchronisers for the asynchronous lock and button inputs.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            lock_meta_r <= 1'b0;
            lock_s_r    <= 1'b0;
            btn_meta_r  <= 1'b0;
            btn_s_r     <= 1'b0;
        end else begin
            lock_meta_r <= LOCKED_IN;
            lock_s_r    <= lock_meta_r;
            btn_meta_r  <= BTN_RST_IN;
            btn_s_r     <= btn_meta_r;
        end
    end

    // Button debouncer: a sample equal to the debounced state restarts the count.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            btn_db_r <= 1'b0;
            db_cnt_r <= 20'd0;
        end else if (btn_s_r == btn_db_r) begin
            db_cnt_r <= 20'd0;
        end else if (db_cnt_r == DB_LAST) begin
            btn_db_r <= btn_s_r;
            db_cnt_r <= 20'd0;
        end else begin
            db_cnt_r <= db_cnt_r + 20'd1;
        end
    end

    // Saturating counter of synchronised lock falling edges.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            lock_prev_r <= 1'b0;
            loss_cnt_r  <= 8'd0;
        end else begin
            lock_prev_r <= lock_s_r;
            if (lock_prev_r && !lock_s_r && (loss_cnt_r != 8'hFF)) begin
                loss_cnt_r <= loss_cnt_r + 8'd1;
            end
        end
    end

    // Abort detection with lock loss taking priority over button, then software.
    always_comb begin
        abort_s     = (!lock_s_r) || btn_db_r || SW_RST_IN;
        cause_nxt_s = CAUSE_SW;
        if (!lock_s_r) begin
            cause_nxt_s = CAUSE_LOCK;
        end else if (btn_db_r) begin
            cause_nxt_s = CAUSE_BTN;
        end else begin
            cause_nxt_s = CAUSE_SW;
        end
    end

    // Sequencing FSM with registered reset, done and cause outputs.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            state_r   <= ST_HOLD;
            cnt_r     <= 16'd0;
            ch_r      <= 4'd0;
            rst_out_r <= {NUM_CH{1'b1}};
            done_r    <= 1'b0;
            cause_r   <= 2'd0;
        end else if ((state_r != ST_HOLD) && abort_s) begin
            state_r   <= ST_HOLD;
            cnt_r     <= 16'd0;
            ch_r      <= 4'd0;
            rst_out_r <= {NUM_CH{1'b1}};
            done_r    <= 1'b0;
            cause_r   <= cause_nxt_s;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    rst_out_r <= {NUM_CH{1'b1}};
                    done_r    <= 1'b0;
                    cnt_r     <= 16'd0;
                    if (lock_s_r && !btn_db_r) begin
                        state_r <= ST_STRETCH;
                    end
                end
                ST_STRETCH: begin
                    if (cnt_r == STRETCH_LAST) begin
                        cnt_r        <= 16'd0;
                        ch_r         <= 4'd1;
                        rst_out_r[0] <= 1'b0;
                        if (NUM_CH == 1) begin
                            state_r <= ST_RUN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RELEASE;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r <= 16'd0;
                        ch_r  <= ch_r + 4'd1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (4'(i) == ch_r) begin
                                rst_out_r[i] <= 1'b0;
                            end
                        end
                        if (ch_r == LAST_CH) begin
                            state_r <= ST_RUN;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RUN: begin
                    rst_out_r <= {NUM_CH{1'b0}};
                    done_r    <= 1'b1;
                end
                default: begin
                    state_r   <= ST_HOLD;
                    rst_out_r <= {NUM_CH{1'b1}};
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign RST_OUT           = rst_out_r;
    assign RST_DONE_OUT      = done_r;
    assign RST_CAUSE_OUT     = cause_r;
    assign LOCK_LOSS_CNT_OUT = loss_cnt_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed self-checking bench for rst_seq_ctrl (NUM_CH=3, STRETCH=16, GAP=4, DEBOUNCE=8).
module tb_rst_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST_SYNC;
    logic       LOCKED_IN;
    logic       BTN_RST_IN;
    logic       SW_RST_IN;
    logic [2:0] RST_OUT;
    logic       RST_DONE_OUT;
    logic [1:0] RST_CAUSE_OUT;
    logic [7:0] LOCK_LOSS_CNT_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    rst_seq_ctrl #(
        .NUM_CH(3), .STRETCH_CYCLES(16), .STAGE_GAP(4), .DEBOUNCE_CYCLES(8)
    ) dut (
        .CLK(CLK), .RST_SYNC(RST_SYNC), .LOCKED_IN(LOCKED_IN),
        .BTN_RST_IN(BTN_RST_IN), .SW_RST_IN(SW_RST_IN),
        .RST_OUT(RST_OUT), .RST_DONE_OUT(RST_DONE_OUT),
        .RST_CAUSE_OUT(RST_CAUSE_OUT), .LOCK_LOSS_CNT_OUT(LOCK_LOSS_CNT_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] exp_rst;
        RST_SYNC = 1'b1; LOCKED_IN = 1'b1; BTN_RST_IN = 1'b0; SW_RST_IN = 1'b0;
        repeat (3) tick();
        n_checks++; if (RST_OUT !== 3'b111) begin n_fail++; $display("FAIL reset_rst got %b exp 111", RST_OUT); end
        n_checks++; if (RST_DONE_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", RST_DONE_OUT); end
        n_checks++; if (RST_CAUSE_OUT !== 2'd0) begin n_fail++; $display("FAIL reset_cause got %0d exp 0", RST_CAUSE_OUT); end
        n_checks++; if (LOCK_LOSS_CNT_OUT !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", LOCK_LOSS_CNT_OUT); end
        RST_SYNC = 1'b0;
        for (int n = 1; n <= 27; n++) begin
            tick();
            exp_rst = (n < 19) ? 3'b111 : (n < 23) ? 3'b110 : (n < 27) ? 3'b100 : 3'b000;
            n_checks++;
            if (RST_OUT !== exp_rst) begin n_fail++; $display("FAIL powerup_rst edge %0d got %b exp %b", n, RST_OUT, exp_rst); end
            n_checks++;
            if (RST_DONE_OUT !== (n == 27)) begin n_fail++; $display("FAIL powerup_done edge %0d got %b", n, RST_DONE_OUT); end
        end
        n_checks++; if (RST_CAUSE_OUT !== 2'd0) begin n_fail++; $display("FAIL powerup_cause got %0d exp 0", RST_CAUSE_OUT); end
    endtask

    task automatic test_lock_loss();
        logic [2:0] exp_rst;
        LOCKED_IN = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 3) LOCKED_IN = 1'b1;
            exp_rst = (k < 3) ? 3'b000 : (k < 22) ? 3'b111 : (k < 26) ? 3'b110 : (k < 30) ? 3'b100 : 3'b000;
            n_checks++;
            if (RST_OUT !== exp_rst) begin n_fail++; $display("FAIL lockloss_rst edge %0d got %b exp %b", k, RST_OUT, exp_rst); end
            if (k == 3) begin
                n_checks++; if (RST_CAUSE_OUT !== 2'd1) begin n_fail++; $display("FAIL lockloss_cause got %0d exp 1", RST_CAUSE_OUT); end
                n_checks++; if (LOCK_LOSS_CNT_OUT !== 8'd1) begin n_fail++; $display("FAIL lockloss_cnt got %0d exp 1", LOCK_LOSS_CNT_OUT); end
                n_checks++; if (RST_DONE_OUT !== 1'b0) begin n_fail++; $display("FAIL lockloss_done got %b exp 0", RST_DONE_OUT); end
            end
        end
        n_checks++; if (RST_DONE_OUT !== 1'b1) begin n_fail++; $display("FAIL lockloss_redone got %b exp 1", RST_DONE_OUT); end
    endtask

    task automatic test_button();
        logic [2:0] exp_rst;
        // Short pulse must be filtered out.
        BTN_RST_IN = 1'b1;
        repeat (5) tick();
        BTN_RST_IN = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++;
            if (RST_OUT !== 3'b000) begin n_fail++; $display("FAIL btn_glitch edge %0d got %b exp 000", k, RST_OUT); end
        end
        BTN_RST_IN = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            tick();
            if (k == 20) BTN_RST_IN = 1'b0;
            exp_rst = (k < 11) ? 3'b000 : (k < 47) ? 3'b111 : (k < 51) ? 3'b110 : (k < 55) ? 3'b100 : 3'b000;
            n_checks++;
            if (RST_OUT !== exp_rst) begin n_fail++; $display("FAIL btn_rst edge %0d got %b exp %b", k, RST_OUT, exp_rst); end
            if (k == 11) begin
                n_checks++; if (RST_CAUSE_OUT !== 2'd2) begin n_fail++; $display("FAIL btn_cause got %0d exp 2", RST_CAUSE_OUT); end
            end
        end
    endtask

    task automatic test_sw_priority();
        SW_RST_IN = 1'b1;
        tick();
        SW_RST_IN = 1'b0;
        n_checks++; if (RST_OUT !== 3'b111) begin n_fail++; $display("FAIL sw_rst got %b exp 111", RST_OUT); end
        n_checks++; if (RST_CAUSE_OUT !== 2'd3) begin n_fail++; $display("FAIL sw_cause got %0d exp 3", RST_CAUSE_OUT); end
        // One HOLD cycle, then STRETCH from edge 2; bit 0 released at edge 18.
        for (int k = 2; k <= 18; k++) tick();
        n_checks++; if (RST_OUT !== 3'b110) begin n_fail++; $display("FAIL sw_rerelease got %b exp 110", RST_OUT); end
        // Software pulse lands on the edge where the lock drop becomes visible internally.
        LOCKED_IN = 1'b0;
        tick(); tick();
        n_checks++; if (RST_OUT !== 3'b110) begin n_fail++; $display("FAIL prio_pre got %b exp 110", RST_OUT); end
        SW_RST_IN = 1'b1;
        tick();
        SW_RST_IN = 1'b0;
        n_checks++; if (RST_OUT !== 3'b111) begin n_fail++; $display("FAIL prio_rst got %b exp 111", RST_OUT); end
        n_checks++; if (RST_CAUSE_OUT !== 2'd1) begin n_fail++; $display("FAIL prio_cause got %0d exp 1", RST_CAUSE_OUT); end
        n_checks++; if (LOCK_LOSS_CNT_OUT !== 8'd2) begin n_fail++; $display("FAIL prio_cnt got %0d exp 2", LOCK_LOSS_CNT_OUT); end
        tick();
        SW_RST_IN = 1'b1;
        tick();
        SW_RST_IN = 1'b0;
        repeat (3) tick();
        n_checks++; if (RST_CAUSE_OUT !== 2'd1) begin n_fail++; $display("FAIL hold_sw_cause got %0d exp 1", RST_CAUSE_OUT); end
        n_checks++; if (RST_OUT !== 3'b111) begin n_fail++; $display("FAIL hold_sw_rst got %b exp 111", RST_OUT); end
        LOCKED_IN = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        for (int e = 1; e <= 300; e++) begin
            LOCKED_IN = 1'b0;
            repeat (3) tick();
            LOCKED_IN = 1'b1;
            repeat (3) tick();
            if (e == 100) begin
                n_checks++; if (LOCK_LOSS_CNT_OUT !== 8'd102) begin n_fail++; $display("FAIL sat_mid got %0d exp 102", LOCK_LOSS_CNT_OUT); end
            end
        end
        n_checks++; if (LOCK_LOSS_CNT_OUT !== 8'd255) begin n_fail++; $display("FAIL sat_cnt got %0d exp 255", LOCK_LOSS_CNT_OUT); end
        repeat (4) tick();
        n_checks++; if (RST_OUT !== 3'b111) begin n_fail++; $display("FAIL mid_stretch got %b exp 111", RST_OUT); end
        RST_SYNC = 1'b1;
        tick();
        RST_SYNC = 1'b0;
        n_checks++; if (LOCK_LOSS_CNT_OUT !== 8'd0) begin n_fail++; $display("FAIL srst_cnt got %0d exp 0", LOCK_LOSS_CNT_OUT); end
        n_checks++; if (RST_OUT !== 3'b111) begin n_fail++; $display("FAIL srst_rst got %b exp 111", RST_OUT); end
        n_checks++; if (RST_DONE_OUT !== 1'b0) begin n_fail++; $display("FAIL srst_done got %b exp 0", RST_DONE_OUT); end
        n_checks++; if (RST_CAUSE_OUT !== 2'd0) begin n_fail++; $display("FAIL srst_cause got %0d exp 0", RST_CAUSE_OUT); end
    endtask

    initial begin
        test_reset();
        test_lock_loss();
        test_button();
        test_sw_priority();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised reset sequencer for the FPGA top level. It holds every core domain in reset until the DCM lock is stable, then stretches the reset and releases NUM_CH reset channels one after another in a fixed order. It re-runs the whole sequence on lock loss, a debounced push-button, or a software request. It records the reset cause and counts lock-loss events for debug visibility on LEDs/7-seg.

## Interface
- NUM_CH, 4: number of sequenced reset outputs (1..8)
- STRETCH_CYCLES, 16: cycles of stable lock required before the first release (2..65535)
- STAGE_GAP, 8: cycles between consecutive channel releases (1..65535)
- DEBOUNCE_CYCLES, 1024: consecutive equal button samples needed to change the debounced state (2..2^20)

- CLK  in  1  system clock
- RST_SYNC  in  1  synchronous active-high reset
- LOCKED_IN  in  1  DCM LOCKED, asynchronous; 2-flop synchronised internally
- BTN_RST_IN  in  1  push-button reset, asynchronous, active-high; 2-flop synchronised then debounced
- SW_RST_IN  in  1  single-cycle synchronous software reset request
- RST_OUT  out  NUM_CH  active-high resets; bit 0 released first
- RST_DONE_OUT  out  1  high when all channels are released
- RST_CAUSE_OUT  out  2  last reset cause: 0 power-on/RST_SYNC, 1 lock loss, 2 button, 3 software
- LOCK_LOSS_CNT_OUT  out  8  saturating count of synchronised lock falling edges

## Operation
- Reset values under RST_SYNC:
  - RST_OUT all 1s, RST_DONE_OUT 0, RST_CAUSE_OUT 0, LOCK_LOSS_CNT_OUT 0
  - sync flops 0, debounced button 0
  - state HOLD, counters 0
- States:
  - HOLD: all RST_OUT high. Go to STRETCH with cnt=0 when lock_s=1 and btn_db=0.
  - STRETCH: all RST_OUT high. cnt increments each cycle. When cnt==STRETCH_CYCLES-1, go to RELEASE, clear RST_OUT[0], and set cnt=0, ch=1.
  - RELEASE: cnt increments. When cnt==STAGE_GAP-1, clear RST_OUT[ch], increment ch, and set cnt=0. Clearing RST_OUT[NUM_CH-1] moves to RUN and sets RST_DONE_OUT.
  - RUN: all RST_OUT low, RST_DONE_OUT high.
  - If NUM_CH==1, STRETCH goes directly to RUN.
- Abort triggers: lock_s==0, btn_db==1, or SW_RST_IN==1.
  - Evaluated in every state except HOLD.
  - On a trigger: next state HOLD, all RST_OUT set to 1 and RST_DONE_OUT cleared at the same edge, RST_CAUSE_OUT updated.
  - Cause priority when triggers coincide: lock loss > button > software.
- In HOLD, SW_RST_IN is ignored. Cause updates only on entry to HOLD.
- A software request with lock and button OK gives 1 cycle in HOLD, then a full STRETCH.
- Debounce: btn_db takes the value of the synchronised button after it has been constant for DEBOUNCE_CYCLES consecutive cycles. Any change restarts the counter.
- LOCK_LOSS_CNT_OUT:
  - increments on each synchronised 1→0 lock transition in any state, including HOLD
  - saturates at 255
  - cleared only by RST_SYNC
- Release order is strictly ascending. A higher channel is never released before a lower one.

## Timing
- Edge n means the nth rising CLK edge with RST_SYNC low.
- All outputs are registered. No combinational path from inputs to outputs.
- LOCKED_IN to lock_s latency: 2 cycles.
- Button to btn_db latency: 2 + DEBOUNCE_CYCLES cycles.
- Abort reaction:
  - RST_OUT asserts 1 edge after a trigger is visible internally.
  - That is 3 edges after a LOCKED_IN fall.
  - It is 1 edge after SW_RST_IN.
- Release timing, with LOCKED_IN high throughout and btn low:
  - HOLD→STRETCH at edge 3
  - RST_OUT[0] low after edge 3+STRETCH_CYCLES
  - RST_OUT[k] low STAGE_GAP·k edges later
  - RST_DONE_OUT rises with the last release
- RST_SYNC asserted mid-sequence: all outputs return to reset values at the next edge, and LOCK_LOSS_CNT_OUT clears.
- Lock loss during STRETCH: full restart. Partial stretch credit is not retained.

## Test plan
- Power-up with NUM_CH=3, STRETCH_CYCLES=16, STAGE_GAP=4, LOCKED_IN high; release RST_SYNC.
  - Required: RST_OUT=111 through edge 18, 110 after edge 19, 100 after edge 23, 000 after edge 27.
  - RST_DONE_OUT rises after edge 27. RST_CAUSE_OUT=0.
- LOCKED_IN low for 3 cycles while in RUN.
  - Required: RST_OUT=111 three edges after the fall, RST_CAUSE_OUT=1, LOCK_LOSS_CNT_OUT=1.
  - The full 16+4+4 re-sequence starts once lock returns.
- Button with DEBOUNCE_CYCLES=8:
  - a 5-cycle pulse causes no reset
  - a 20-cycle press asserts RST_OUT=111 within 11 edges, with RST_CAUSE_OUT=2
  - release starts only after btn_db clears
- SW_RST_IN pulse during RELEASE (RST_OUT=110) in the same cycle as a LOCKED_IN drop.
  - Required: RST_OUT=111, RST_CAUSE_OUT=1 (lock priority).
  - Also check that SW_RST_IN asserted in HOLD has no effect.
- 300 lock-loss events.
  - Required: LOCK_LOSS_CNT_OUT saturates at 255.
  - Then assert RST_SYNC mid-STRETCH and check: counter 0, RST_OUT=111, RST_DONE_OUT=0, RST_CAUSE_OUT=0 on the next edge.
